hht_gather_fifo: RTL and testbench

Parametrised successor of the HHT control engine: walks a column-index array (`col_base`, `csize` entries), gathers the indexed vector values through a two-port memory interface, and buffers them in a DEPTH-entry FIFO. The CPU drains the results through a memory-mapped read window, and `hht` acts as the data-ready handshake. Compared with the previous generation, it adds:
- a full pipeline sustaining one element per cycle;
- credit-based back-pressure;
- out-of-range index protection;
- a status register;
- restart and flush.

---
 rtl/hht_gather_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_hht_gather_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hht_gather_fifo.sv
// Gather engine: walks a column-index array, fetches the indexed vector values
// through a three-stage pipeline and buffers them in a credit-protected FIFO that a CPU drains.
module hht_gather_fifo #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int DEPTH    = 8,
   parameter int VEC_LEN  = 16,
   parameter int HHT_ADDR = 126
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] col_base,
   input  logic [ADDR_W-1:0] v_base,
   input  logic [31:0]       csize,
   output logic [ADDR_W-1:0] idx_addr,
   input  logic [DATA_W-1:0] idx_data,
   output logic [ADDR_W-1:0] val_addr,
   input  logic [DATA_W-1:0] val_data,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_rd,
   output logic              hht,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CS_W  = CNT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_r;
   logic [ADDR_W-1:0]   col_base_r;
   logic [ADDR_W-1:0]   v_base_r;
   logic [31:0]         csize_r;
   logic [31:0]         issue_cnt_r;
   logic [31:0]         push_cnt_r;
   logic [ADDR_W-1:0]   idx_addr_r;
   logic [ADDR_W-1:0]   val_addr_r;
   logic                s1_r;
   logic                s2_r;
   logic                s2_oor_r;
   logic                busy_r;
   logic                done_r;
   logic                err_r;

   logic [DATA_W-1:0]   fifo_mem_r [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [CNT_W-1:0]    count_r;

   logic                start_ok_s;
   logic                issue_s;
   logic                credit_ok_s;
   logic [CS_W-1:0]     credit_sum_s;
   logic                idx_oor_s;
   logic                push_s;
   logic                pop_s;
   logic [DATA_W-1:0]   push_data_s;
   logic [DATA_W-1:0]   status_s;
   logic                hht_s;
   logic [DATA_W-1:0]   rdata_s;

   // Credit counts in-flight pipeline slots so a same-cycle pop never grants an extra issue.
   assign credit_sum_s = {1'b0, count_r} + {{CNT_W{1'b0}}, s1_r} + {{CNT_W{1'b0}}, s2_r};
   assign credit_ok_s  = credit_sum_s < CS_W'(DEPTH);
   assign start_ok_s   = start && (state_r != ST_RUN);
   assign issue_s      = (state_r == ST_RUN) && (issue_cnt_r < csize_r) && credit_ok_s;
   assign idx_oor_s    = idx_data >= DATA_W'(VEC_LEN);
   assign push_s       = s2_r && !start_ok_s;
   assign push_data_s  = s2_oor_r ? {DATA_W{1'b0}} : val_data;

   // Control FSM, issue/S1/S2 pipeline and sticky error flag
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_r     <= ST_IDLE;
         col_base_r  <= {ADDR_W{1'b0}};
         v_base_r    <= {ADDR_W{1'b0}};
         csize_r     <= 32'd0;
         issue_cnt_r <= 32'd0;
         push_cnt_r  <= 32'd0;
         idx_addr_r  <= {ADDR_W{1'b0}};
         val_addr_r  <= {ADDR_W{1'b0}};
         s1_r        <= 1'b0;
         s2_r        <= 1'b0;
         s2_oor_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else if (start_ok_s) begin
         col_base_r  <= col_base;
         v_base_r    <= v_base;
         csize_r     <= csize;
         issue_cnt_r <= 32'd0;
         push_cnt_r  <= 32'd0;
         s1_r        <= 1'b0;
         s2_r        <= 1'b0;
         s2_oor_r    <= 1'b0;
         err_r       <= 1'b0;
         if (csize == 32'd0) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
         end else begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
         end
      end else begin
         s1_r     <= issue_s;
         s2_r     <= s1_r;
         s2_oor_r <= s1_r && idx_oor_s;
         if (issue_s) begin
            idx_addr_r  <= col_base_r + ADDR_W'(issue_cnt_r);
            issue_cnt_r <= issue_cnt_r + 32'd1;
         end
         // An out-of-range index leaves val_addr untouched; S2 substitutes zero.
         if (s1_r && !idx_oor_s) begin
            val_addr_r <= v_base_r + ADDR_W'(idx_data);
         end
         if (s2_r) begin
            push_cnt_r <= push_cnt_r + 32'd1;
            if (s2_oor_r) begin
               err_r <= 1'b1;
            end
            if (push_cnt_r == csize_r - 32'd1) begin
               state_r <= ST_DONE;
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
            end
         end
      end
   end

   // FIFO storage; only entries between rd_ptr and wr_ptr carry meaning
   always_ff @(posedge Clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= push_data_s;
      end
   end

   // FIFO pointers and occupancy; a honoured start flushes and overrides any pop
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (start_ok_s) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

   // Status word: err, done, busy above a zero-extended occupancy
   always_comb begin
      status_s       = {DATA_W{1'b0}};
      status_s[15:0] = 16'(count_r);
      status_s[16]   = busy_r;
      status_s[17]   = done_r;
      status_s[18]   = err_r;
   end

   // CPU window decode; gated by reset so outputs are quiet while Rst is low
   always_comb begin
      hht_s   = 1'b0;
      rdata_s = {DATA_W{1'b0}};
      pop_s   = 1'b0;
      if (cpu_rd && Rst) begin
         if (cpu_addr == ADDR_W'(HHT_ADDR)) begin
            if (count_r != {CNT_W{1'b0}}) begin
               hht_s   = 1'b1;
               rdata_s = fifo_mem_r[rd_ptr_r];
               pop_s   = 1'b1;
            end else begin
               hht_s   = 1'b0;
            end
         end else if (cpu_addr == ADDR_W'(HHT_ADDR + 1)) begin
            hht_s   = 1'b1;
            rdata_s = status_s;
         end else begin
            hht_s   = 1'b0;
         end
      end else begin
         hht_s = 1'b0;
      end
   end

   assign idx_addr = idx_addr_r;
   assign val_addr = val_addr_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign err      = err_r;
   assign hht      = hht_s;
   assign rdata    = rdata_s;

endmodule

// File: tb/tb_hht_gather_fifo.sv
// Directed + randomized bench for hht_gather_fifo; expected data comes from a
// queue-based gather model built from the memory contents at each start.
module tb_hht_gather_fifo;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int DEPTH = 4;
   localparam int VL = 16;
   localparam int HA = 126;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          start;
   logic [AW-1:0] col_base;
   logic [AW-1:0] v_base;
   logic [31:0]   csize;
   logic [AW-1:0] idx_addr;
   logic [DW-1:0] idx_data;
   logic [AW-1:0] val_addr;
   logic [DW-1:0] val_data;
   logic [AW-1:0] cpu_addr;
   logic          cpu_rd;
   logic          hht;
   logic [DW-1:0] rdata;
   logic          busy;
   logic          done;
   logic          err;

   logic [31:0] idx_mem [0:255];
   logic [31:0] val_mem [0:255];

   int n_pass = 0;
   int n_fail = 0;
   int n_chk  = 0;
   logic [31:0] exp_q [$];
   logic        exp_err;

   hht_gather_fifo #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .VEC_LEN(VL), .HHT_ADDR(HA)
   ) dut (
      .Clk(Clk), .Rst(Rst), .start(start), .col_base(col_base), .v_base(v_base),
      .csize(csize), .idx_addr(idx_addr), .idx_data(idx_data), .val_addr(val_addr),
      .val_data(val_data), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .hht(hht),
      .rdata(rdata), .busy(busy), .done(done), .err(err)
   );

   always #5 Clk = ~Clk;

   assign idx_data = idx_mem[idx_addr[7:0]];
   assign val_data = val_mem[val_addr[7:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Gather model: element k is val[v_base+idx[col_base+k]], or 0 when the index is out of range
   task automatic build_model(input logic [31:0] cb, input logic [31:0] vb, input logic [31:0] n);
      logic [31:0] ix;
      exp_q.delete();
      exp_err = 1'b0;
      for (int k = 0; k < int'(n); k++) begin
         ix = idx_mem[(cb + k) % 256];
         if (ix < VL) exp_q.push_back(val_mem[(vb + ix) % 256]);
         else begin
            exp_q.push_back(32'd0);
            exp_err = 1'b1;
         end
      end
   endtask

   task automatic do_start(input logic [31:0] cb, input logic [31:0] vb, input logic [31:0] n);
      @(negedge Clk);
      cpu_rd = 1'b0;
      col_base = cb; v_base = vb; csize = n; start = 1'b1;
      build_model(cb, vb, n);
      @(negedge Clk);
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge Clk);
         cpu_rd = 1'b0;
      end
   endtask

   task automatic read_one(input string tag, input int budget);
      bit got;
      got = 1'b0;
      for (int w = 0; w < budget && !got; w++) begin
         @(negedge Clk);
         cpu_rd = 1'b1; cpu_addr = 32'(HA);
         #1;
         if (hht === 1'b1) begin
            got = 1'b1;
            if (exp_q.size() == 0) check({tag, "_extra"}, 32'd1, 32'd0);
            else check(tag, rdata, exp_q.pop_front());
         end
      end
      if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic stat_read(output logic [31:0] s);
      @(negedge Clk);
      cpu_rd = 1'b1; cpu_addr = 32'(HA + 1);
      #1;
      check("stat_hht", {31'd0, hht}, 32'd1);
      s = rdata;
   endtask

   task automatic empty_read(input string tag);
      @(negedge Clk);
      cpu_rd = 1'b1; cpu_addr = 32'(HA);
      #1;
      check({tag, "_hht"}, {31'd0, hht}, 32'd0);
      check({tag, "_rdata"}, rdata, 32'd0);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int w;
      w = 0;
      while (done !== 1'b1 && w < budget) begin
         @(negedge Clk);
         cpu_rd = 1'b0;
         w++;
      end
      check(tag, {31'd0, done}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] s;
      logic [31:0] held;
      int got, first, last;

      for (int a = 0; a < 256; a++) begin
         idx_mem[a] = 32'd0;
         val_mem[a] = 32'd0;
      end
      Rst = 1'b0; start = 1'b0; cpu_rd = 1'b0; cpu_addr = 32'd0;
      col_base = 32'd0; v_base = 32'd0; csize = 32'd0;
      repeat (2) @(negedge Clk);
      check("rst_idx_addr", idx_addr, 32'd0);
      check("rst_val_addr", val_addr, 32'd0);
      check("rst_flags", {28'd0, busy, done, err, hht}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      Rst = 1'b1;

      // Empty, status and foreign-address reads while idle
      empty_read("idle_empty");
      stat_read(s);
      check("idle_status", s, 32'd0);
      @(negedge Clk);
      cpu_rd = 1'b1; cpu_addr = 32'd125;
      #1;
      check("other_addr", {hht, rdata[30:0]}, 32'd0);

      // Basic gather with cycle-exact latency
      for (int a = 2; a < 18; a++) val_mem[a] = $urandom;
      idx_mem[180] = 32'd15; idx_mem[181] = 32'd2; idx_mem[182] = 32'd11; idx_mem[183] = 32'd7;
      val_mem[17] = 32'd34; val_mem[4] = 32'd68; val_mem[13] = 32'd52; val_mem[9] = 32'd8;
      do_start(32'd180, 32'd2, 32'd4);
      check("basic_busy_t0", {30'd0, busy, done}, 32'd2);
      @(negedge Clk);
      check("basic_idx_t1", idx_addr, 32'd180);
      @(negedge Clk);
      check("basic_val_t2", val_addr, 32'd17);
      cpu_rd = 1'b1; cpu_addr = 32'(HA);
      #1;
      check("basic_early_hht", {31'd0, hht}, 32'd0);
      for (int k = 3; k <= 6; k++) begin
         @(negedge Clk);
         cpu_rd = 1'b1; cpu_addr = 32'(HA);
         #1;
         check("basic_hht", {31'd0, hht}, 32'd1);
         check("basic_data", rdata, (k == 3) ? 32'd34 : (k == 4) ? 32'd68 : (k == 5) ? 32'd52 : 32'd8);
         if (k == 5) check("basic_done_early", {31'd0, done}, 32'd0);
         if (k == 6) check("basic_done", {30'd0, busy, done}, 32'd1);
      end
      empty_read("basic_drained");

      // Back-pressure: no reads until the FIFO and pipeline saturate
      for (int a = 40; a < 50; a++) idx_mem[a] = $urandom_range(0, VL - 1);
      for (int a = 100; a < 116; a++) val_mem[a] = $urandom;
      do_start(32'd40, 32'd100, 32'd10);
      for (int c = 0; c < 20; c++) begin
         stat_read(s);
         check("bp_cnt_le_depth", {31'd0, s[15:0] <= DEPTH}, 32'd1);
      end
      stat_read(s);
      check("bp_status_full", s, 32'h0001_0004);
      check("bp_idx_stalled", idx_addr, 32'd43);
      // start during RUN must be ignored
      @(negedge Clk);
      cpu_rd = 1'b0; csize = 32'd0; start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      idle(3);
      stat_read(s);
      check("bp_start_ignored", s, 32'h0001_0004);
      check("bp_idx_still", idx_addr, 32'd43);
      for (int k = 0; k < 10; k++) read_one("bp_data", 8);
      wait_done("bp_done", 20);
      empty_read("bp_drained");

      // Out-of-range index sets err and yields a zero element
      idx_mem[60] = 32'd3; idx_mem[61] = 32'd20;
      val_mem[153] = $urandom;
      do_start(32'd60, 32'd150, 32'd2);
      read_one("oor_first", 8);
      read_one("oor_zero", 8);
      idle(1);
      check("oor_err", {31'd0, err}, {31'd0, exp_err});
      stat_read(s);
      check("oor_status", s[18:16], 3'b110);
      held = idx_addr;

      // csize==0 start: straight to DONE, err cleared, no fetch
      do_start(32'd200, 32'd0, 32'd0);
      check("zero_flags", {29'd0, busy, done, err}, 32'd2);
      idle(3);
      check("zero_idx_held", idx_addr, held);

      // Concurrency: continuous reads while streaming
      for (int a = 10; a < 22; a++) idx_mem[a] = $urandom_range(0, VL + 3);
      for (int a = 120; a < 140; a++) val_mem[a] = $urandom;
      do_start(32'd10, 32'd120, 32'd12);
      got = 0; first = -1; last = -1;
      for (int c = 0; c < 30; c++) begin
         @(negedge Clk);
         cpu_rd = 1'b1; cpu_addr = 32'(HA);
         #1;
         if (hht === 1'b1) begin
            got++;
            if (first < 0) first = c;
            last = c;
            if (exp_q.size() == 0) check("conc_extra", 32'd1, 32'd0);
            else check("conc_data", rdata, exp_q.pop_front());
         end
      end
      check("conc_count", 32'(got), 32'd12);
      check("conc_span", 32'(last - first), 32'd11);
      check("conc_err", {30'd0, err, done}, {30'd0, exp_err, 1'b1});

      // Asynchronous reset mid-RUN with three entries buffered
      for (int a = 80; a < 88; a++) idx_mem[a] = $urandom_range(0, VL - 1);
      for (int a = 30; a < 46; a++) val_mem[a] = $urandom;
      do_start(32'd80, 32'd30, 32'd8);
      idle(4);
      stat_read(s);
      check("rr_count3", s, 32'h0001_0003);
      #1 Rst = 1'b0;
      #1;
      check("rr_idx_addr", idx_addr, 32'd0);
      check("rr_val_addr", val_addr, 32'd0);
      check("rr_flags", {28'd0, busy, done, err, hht}, 32'd0);
      check("rr_rdata", rdata, 32'd0);
      @(negedge Clk);
      cpu_rd = 1'b0;
      Rst = 1'b1;
      for (int a = 30; a < 46; a++) val_mem[a] = $urandom;
      do_start(32'd80, 32'd30, 32'd4);
      for (int k = 0; k < 4; k++) read_one("rr_fresh", 8);
      wait_done("rr_done", 10);
      empty_read("rr_no_stale");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
